// File: rtl/wb_pipe_buf.sv
`default_nettype none
// ============================================================================
// Module   : wb_pipe_buf
// Purpose  : MEM->WB bundle buffer with a small FIFO, empty-queue bypass,
//            write-back stall/flush handling and x0 write suppression.
// Revision : 1.0 - initial release
// ============================================================================
module wb_pipe_buf #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int LANES  = 1,
   parameter int DEPTH  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      flush,
   input  logic                      stall_wb,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES-1:0]          in_wreg,
   input  logic [LANES*ADDR_W-1:0]   in_wd,
   input  logic [LANES*DATA_W-1:0]   in_wdata,
   output logic [LANES-1:0]          wb_wreg,
   output logic [LANES*ADDR_W-1:0]   wb_wd,
   output logic [LANES*DATA_W-1:0]   wb_wdata,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_BW    = LANES * (1 + ADDR_W + DATA_W);

   // Bundle layout in storage: {wreg, wd, wdata}
   logic [c_BW-1:0]           r_mem [DEPTH];
   logic [c_PTR_W-1:0]        r_wr_ptr;
   logic [c_PTR_W-1:0]        r_rd_ptr;
   logic [c_CNT_W-1:0]        r_count;
   logic [LANES-1:0]          r_wb_wreg;
   logic [LANES*ADDR_W-1:0]   r_wb_wd;
   logic [LANES*DATA_W-1:0]   r_wb_wdata;

   logic                      w_push;
   logic                      w_drain;
   logic                      w_empty;
   logic                      w_pop;
   logic                      w_bypass;
   logic                      w_wr;
   logic [c_BW-1:0]           w_in_bundle;
   logic [c_BW-1:0]           w_sel;
   logic [LANES-1:0]          w_sel_wreg;
   logic [LANES*ADDR_W-1:0]   w_sel_wd;
   logic [LANES*DATA_W-1:0]   w_sel_wdata;
   logic [LANES-1:0]          w_mask_wreg;

   assign in_ready    = (r_count < c_CNT_W'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = in_valid & in_ready & rdy & ~flush;
   assign w_drain     = rdy & ~flush & ~stall_wb;
   assign w_pop       = w_drain & ~w_empty;
   assign w_bypass    = w_drain & w_empty & w_push;
   // A bypassed bundle goes straight to the output and never occupies a slot
   assign w_wr        = w_push & ~w_bypass;
   assign w_in_bundle = {in_wreg, in_wd, in_wdata};

   always_comb begin
      w_sel = '0;
      if (w_pop)
         w_sel = r_mem[r_rd_ptr];
      else if (w_bypass)
         w_sel = w_in_bundle;
   end

   assign w_sel_wreg  = w_sel[c_BW-1 -: LANES];
   assign w_sel_wd    = w_sel[LANES*DATA_W +: LANES*ADDR_W];
   assign w_sel_wdata = w_sel[LANES*DATA_W-1:0];

   // Writes to register 0 are architecturally discarded
   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         assign w_mask_wreg[i] = w_sel_wreg[i] & (|w_sel_wd[i*ADDR_W +: ADDR_W]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= w_in_bundle;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_wb_wreg  <= '0;
         r_wb_wd    <= '0;
         r_wb_wdata <= '0;
      end else if (rdy) begin
         if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wb_wreg  <= '0;
            r_wb_wd    <= '0;
            r_wb_wdata <= '0;
         end else begin
            r_wb_wreg  <= w_mask_wreg;
            r_wb_wd    <= w_sel_wd;
            r_wb_wdata <= w_sel_wdata;
            if (w_wr)
               r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)
               r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop)
               r_count <= r_count - 1'b1;
         end
      end
   end

   assign wb_wreg  = r_wb_wreg;
   assign wb_wd    = r_wb_wd;
   assign wb_wdata = r_wb_wdata;
   assign count    = r_count;

endmodule
`default_nettype wire
